// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store sequencer between the memory stage and a
//                single-port data memory with req/ack handshake, byte-lane
//                alignment, ack timeout and load data extension.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
    parameter int N       = 32,
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    input  logic         op_we,
    input  logic [2:0]   op_sel,
    input  logic [N-1:0] op_addr,
    input  logic [N-1:0] op_wdata,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [3:0]   mem_be,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         rsp_valid,
    output logic [N-1:0] rsp_data,
    output logic         rsp_err
);

    localparam logic [2:0]       c_sel_w    = 3'b000;
    localparam logic [2:0]       c_sel_h    = 3'b001;
    localparam logic [2:0]       c_sel_b    = 3'b010;
    localparam logic [2:0]       c_sel_hu   = 3'b011;
    localparam logic [2:0]       c_sel_bu   = 3'b100;
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TMO_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_we;
    logic [2:0]       r_sel;
    logic [1:0]       r_off;
    logic [N-1:0]     r_addr;
    logic [3:0]       r_be;
    logic [N-1:0]     r_wdata;
    logic [TMO_W-1:0] r_cnt;
    logic [N-1:0]     r_rsp_data;

    logic             w_misaligned;
    logic             w_illegal;
    logic             w_op_bad;
    logic [3:0]       w_be;
    logic [N-1:0]     w_wdata;
    logic [N-1:0]     w_lane;
    logic [N-1:0]     w_load_ext;

    // Legality is decided from the live op in IDLE so a bad op never reaches the bus
    always_comb begin
        w_misaligned = ((op_sel == c_sel_w) && (op_addr[1:0] != 2'b00)) ||
                       (((op_sel == c_sel_h) || (op_sel == c_sel_hu)) && op_addr[0]);
        w_illegal    = (op_sel > c_sel_bu) ||
                       (op_we && ((op_sel == c_sel_hu) || (op_sel == c_sel_bu)));
        w_op_bad     = w_misaligned || w_illegal;
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = op_wdata;
        case (op_sel)
            c_sel_w:            w_be = 4'b1111;
            c_sel_h, c_sel_hu: begin
                w_be    = 4'b0011 << op_addr[1:0];
                w_wdata = {2{op_wdata[15:0]}};
            end
            c_sel_b, c_sel_bu: begin
                w_be    = 4'b0001 << op_addr[1:0];
                w_wdata = {4{op_wdata[7:0]}};
            end
            default:            w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_lane     = mem_rdata >> {r_off, 3'b000};
        w_load_ext = w_lane;
        case (r_sel)
            c_sel_h:  w_load_ext = {{(N-16){w_lane[15]}}, w_lane[15:0]};
            c_sel_b:  w_load_ext = {{(N-8){w_lane[7]}}, w_lane[7:0]};
            c_sel_hu: w_load_ext = {{(N-16){1'b0}}, w_lane[15:0]};
            c_sel_bu: w_load_ext = {{(N-8){1'b0}}, w_lane[7:0]};
            default:  w_load_ext = w_lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        mem_req     = 1'b0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = op_valid;
                if (op_valid) begin
                    w_state_nxt = w_op_bad ? S_ERR : S_ACCESS;
                end
            end
            S_ACCESS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                // An ack on the final allowed cycle still completes normally
                if (mem_ack) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_tmo_last) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                rsp_valid   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                rsp_err     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_sel      <= 3'b000;
            r_off      <= 2'b00;
            r_addr     <= '0;
            r_be       <= 4'b0000;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
        end else begin
            if ((r_state == S_IDLE) && op_valid && !w_op_bad) begin
                r_we    <= op_we;
                r_sel   <= op_sel;
                r_off   <= op_addr[1:0];
                r_addr  <= {op_addr[N-1:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_cnt   <= '0;
            end
            if (r_state == S_ACCESS) begin
                if (mem_ack) begin
                    r_rsp_data <= r_we ? '0 : w_load_ext;
                end else begin
                    r_cnt <= r_cnt + TMO_W'(1);
                end
            end
        end
    end

    assign mem_we    = mem_req & r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Directed self-checking bench for lsu_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_we;
    logic [2:0]  op_sel;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int n_chk  = 0;
    int n_pass = 0;

    lsu_ctrl #(.N(32), .TMO_W(4), .TMO_MAX(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_we     (op_we),
        .op_sel    (op_sel),
        .op_addr   (op_addr),
        .op_wdata  (op_wdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata);
        op_valid = 1'b1;
        op_we    = we;
        op_sel   = sel;
        op_addr  = addr;
        op_wdata = wdata;
        #1;
        check("accept_stall", {31'd0, stall}, 32'd1);
        check("accept_no_req", {31'd0, mem_req}, 32'd0);
        step();
        op_valid = 1'b0;
        op_we    = 1'b0;
        op_sel   = 3'b000;
        op_addr  = '0;
        op_wdata = '0;
    endtask

    // Full transaction with ack in the first access cycle
    task automatic run_op(input string tag, input logic we, input logic [2:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rsp);
        present(we, sel, addr, wdata);
        check({tag, "_req"},  {31'd0, mem_req}, 32'd1);
        check({tag, "_we"},   {31'd0, mem_we}, {31'd0, we});
        check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "_be"},   {28'd0, mem_be}, {28'd0, exp_be});
        if (we) check({tag, "_wdata"}, mem_wdata, exp_wdata);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
        check({tag, "_rsp_data"},  rsp_data, exp_rsp);
        check({tag, "_stall"},     {31'd0, stall}, 32'd0);
        check({tag, "_req_off"},   {31'd0, mem_req}, 32'd0);
        step();
        check({tag, "_pulse_end"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_hold"},      rsp_data, exp_rsp);
    endtask

    task automatic run_err(input string tag, input logic we, input logic [2:0] sel,
                           input logic [31:0] addr);
        present(we, sel, addr, 32'h5555_5555);
        check({tag, "_err"},    {31'd0, rsp_err}, 32'd1);
        check({tag, "_no_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_valid"},  {31'd0, rsp_valid}, 32'd0);
        check({tag, "_stall"},  {31'd0, stall}, 32'd0);
        step();
        check({tag, "_err_end"}, {31'd0, rsp_err}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_we     = 1'b0;
        op_sel    = 3'b000;
        op_addr   = '0;
        op_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #12;
        check("rst_stall",     {31'd0, stall}, 32'd0);
        check("rst_req",       {31'd0, mem_req}, 32'd0);
        check("rst_we",        {31'd0, mem_we}, 32'd0);
        check("rst_addr",      mem_addr, 32'd0);
        check("rst_be",        {28'd0, mem_be}, 32'd0);
        check("rst_wdata",     mem_wdata, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_data",  rsp_data, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        run_op("lb",  1'b0, 3'b010, 32'h0000_0103, 32'h0, 32'h80FF_1234, 4'b1000, 32'h0, 32'hFFFF_FF80);
        run_op("lhu", 1'b0, 3'b011, 32'h0000_0102, 32'h0, 32'hBEEF_0000, 4'b1100, 32'h0, 32'h0000_BEEF);
        run_op("lh",  1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'hBEEF_0000, 4'b1100, 32'h0, 32'hFFFF_BEEF);
        run_op("lbu", 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h0000_8000, 4'b0010, 32'h0, 32'h0000_0080);
        run_op("lw",  1'b0, 3'b000, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D);
        run_op("lh0", 1'b0, 3'b001, 32'h0000_0010, 32'h0, 32'h1234_7FFE, 4'b0011, 32'h0, 32'h0000_7FFE);
        run_op("sb",  1'b1, 3'b010, 32'h0000_0201, 32'h0000_00AB, 32'h0, 4'b0010, 32'hABAB_ABAB, 32'h0);
        run_op("sh",  1'b1, 3'b001, 32'h0000_0402, 32'h7777_1234, 32'h0, 4'b1100, 32'h1234_1234, 32'h0);
        run_op("sw",  1'b1, 3'b000, 32'h0000_0504, 32'hDEAD_BEEF, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0);

        run_err("lw_mis",  1'b0, 3'b000, 32'h0000_0002);
        run_err("shu_ill", 1'b1, 3'b011, 32'h0000_0000);
        run_err("sbu_ill", 1'b1, 3'b100, 32'h0000_0000);
        run_err("sel_ill", 1'b0, 3'b101, 32'h0000_0000);
        run_err("lh_mis",  1'b0, 3'b001, 32'h0000_0003);

        // ack while idle must not produce a response
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_0000;
        step();
        mem_ack   = 1'b0;
        check("idle_ack_valid", {31'd0, rsp_valid}, 32'd0);
        check("idle_ack_data",  rsp_data, 32'd0);

        // timeout: no ack at all
        present(1'b0, 3'b000, 32'h0000_0010, 32'h0);
        cyc = 0;
        while (mem_req && cyc < 40) begin
            cyc++;
            step();
        end
        check("tmo_req_cycles", cyc, 32'd15);
        check("tmo_err",        {31'd0, rsp_err}, 32'd1);
        check("tmo_valid",      {31'd0, rsp_valid}, 32'd0);
        step();
        check("tmo_err_end",    {31'd0, rsp_err}, 32'd0);

        // ack on the last allowed cycle completes
        present(1'b0, 3'b000, 32'h0000_0020, 32'h0);
        for (int i = 0; i < 14; i++) step();
        check("tmo15_req", {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_ack   = 1'b0;
        check("tmo15_valid", {31'd0, rsp_valid}, 32'd1);
        check("tmo15_err",   {31'd0, rsp_err}, 32'd0);
        check("tmo15_data",  rsp_data, 32'h1234_5678);
        step();

        // asynchronous reset in the middle of an access
        present(1'b0, 3'b000, 32'h0000_0044, 32'h0);
        check("mid_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",   {31'd0, mem_req}, 32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_addr",  mem_addr, 32'd0);
        check("arst_be",    {28'd0, mem_be}, 32'd0);
        check("arst_data",  rsp_data, 32'd0);
        step();
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack   = 1'b0;
        check("late_ack_valid", {31'd0, rsp_valid}, 32'd0);
        check("late_ack_data",  rsp_data, 32'd0);
        check("late_ack_req",   {31'd0, mem_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
